// File: rtl/m8_frame_serializer.sv
// Fetches 12-bit frame words from the filler and shifts them out MSB-first as gapless NRZ at clk/CLK_DIV.
// First bit appears 3 cycles after enable; no backpressure, and enable low stops cleanly at the next word boundary.
module m8_frame_serializer #(
    parameter int CLK_DIV      = 20,
    parameter int FRAME_WORDS  = 1024,
    parameter int GROUP_FRAMES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] dataWord,
    output logic        bufGetWord,
    output logic [9:0]  bufRdPointer,
    output logic [4:0]  cntGrp,
    output logic        serOut,
    output logic        bitStrobe,
    output logic        frameSync,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        SHIFT
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [9:0] PTR_LAST  = 10'(FRAME_WORDS - 1);
    localparam logic [4:0] GRP_LAST  = 5'(GROUP_FRAMES - 1);
    localparam logic [3:0] BIT_FIRST = 4'd11;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] shreg;
    logic [11:0] shreg_nxt;
    logic [11:0] hold;
    logic [11:0] hold_nxt;
    logic        cur_w0;
    logic        cur_w0_nxt;
    logic        hold_w0;
    logic        hold_w0_nxt;
    logic [3:0]  bitcnt;
    logic [3:0]  bitcnt_nxt;
    logic [7:0]  div;
    logic [7:0]  div_nxt;
    logic [9:0]  ptr_nxt;
    logic [4:0]  grp_nxt;

    logic        in_shift;
    logic        first_bit;
    logic        bit_end;
    logic        word_end;

    assign in_shift  = (state == SHIFT);
    assign first_bit = (bitcnt == BIT_FIRST);
    assign bit_end   = (div == DIV_LAST);
    assign word_end  = bit_end && (bitcnt == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shreg        <= '0;
            hold         <= '0;
            cur_w0       <= 1'b0;
            hold_w0      <= 1'b0;
            bitcnt       <= '0;
            div          <= '0;
            bufRdPointer <= '0;
            cntGrp       <= '0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            hold         <= hold_nxt;
            cur_w0       <= cur_w0_nxt;
            hold_w0      <= hold_w0_nxt;
            bitcnt       <= bitcnt_nxt;
            div          <= div_nxt;
            bufRdPointer <= ptr_nxt;
            cntGrp       <= grp_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        hold_nxt    = hold;
        cur_w0_nxt  = cur_w0;
        hold_w0_nxt = hold_w0;
        bitcnt_nxt  = bitcnt;
        div_nxt     = div;
        ptr_nxt     = bufRdPointer;
        grp_nxt     = cntGrp;

        bufGetWord  = 1'b0;
        serOut      = 1'b0;
        bitStrobe   = 1'b0;
        frameSync   = 1'b0;
        busy        = (state != IDLE);

        case (state)
            IDLE: begin
                ptr_nxt = '0;
                if (enable) begin
                    state_nxt = REQ;
                end
            end

            REQ: begin
                bufGetWord = 1'b1;
                state_nxt  = WAIT;
            end

            // Word 0 arrives here; the enable level is deliberately ignored so it always goes out whole.
            WAIT: begin
                shreg_nxt  = dataWord;
                cur_w0_nxt = 1'b1;
                ptr_nxt    = 10'd1;
                bitcnt_nxt = BIT_FIRST;
                div_nxt    = '0;
                state_nxt  = SHIFT;
            end

            SHIFT: begin
                serOut     = shreg[11];
                bitStrobe  = (div == 8'd0);
                frameSync  = (div == 8'd0) && first_bit && cur_w0;
                bufGetWord = first_bit && (div == 8'd1);
                div_nxt    = bit_end ? 8'd0 : div + 8'd1;

                // Prefetched word lands one cycle after the strobe; remember whether it opens a frame.
                if (first_bit && (div == 8'd2)) begin
                    hold_nxt    = dataWord;
                    hold_w0_nxt = (bufRdPointer == 10'd0);
                end

                if (word_end) begin
                    if (enable) begin
                        shreg_nxt  = hold;
                        cur_w0_nxt = hold_w0;
                        bitcnt_nxt = BIT_FIRST;
                        if (bufRdPointer == PTR_LAST) begin
                            ptr_nxt = '0;
                            grp_nxt = (cntGrp == GRP_LAST) ? 5'd0 : cntGrp + 5'd1;
                        end else begin
                            ptr_nxt = bufRdPointer + 10'd1;
                        end
                    end else begin
                        ptr_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else if (bit_end) begin
                    shreg_nxt  = {shreg[10:0], 1'b0};
                    bitcnt_nxt = bitcnt - 4'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_m8_frame_serializer.sv
// Directed bench for m8_frame_serializer with a small filler that answers each read strobe one cycle later.
module tb_m8_frame_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] dataWord = 12'h000;
    logic        bufGetWord;
    logic [9:0]  bufRdPointer;
    logic [4:0]  cntGrp;
    logic        serOut;
    logic        bitStrobe;
    logic        frameSync;
    logic        busy;

    m8_frame_serializer #(
        .CLK_DIV      (4),
        .FRAME_WORDS  (4),
        .GROUP_FRAMES (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .dataWord     (dataWord),
        .bufGetWord   (bufGetWord),
        .bufRdPointer (bufRdPointer),
        .cntGrp       (cntGrp),
        .serOut       (serOut),
        .bitStrobe    (bitStrobe),
        .frameSync    (frameSync),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          run_n = 0;
    int          req_cnt = 0;
    logic        get_d = 1'b0;
    logic [11:0] run_data [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bufGetWord, bufRdPointer, cntGrp, serOut, bitStrobe, frameSync, busy});
    endfunction

    // Advance one cycle; sample point is 1 time unit after the rising edge.
    // The filler drives the requested word only during the cycle after the strobe, noise otherwise.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (get_d) begin
            dataWord = (req_cnt < run_n) ? run_data[req_cnt] : 12'($urandom);
            req_cnt++;
        end else begin
            dataWord = 12'($urandom);
        end
        get_d = bufGetWord;
    endtask

    task automatic check_idle(input string tag, input int grp_exp);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ser"}, 32'(serOut), 32'd0);
        chk({tag, "_ptr"}, 32'(bufRdPointer), 32'd0);
        chk({tag, "_get"}, 32'(bufGetWord), 32'd0);
        chk({tag, "_strb"}, 32'(bitStrobe), 32'd0);
        chk({tag, "_fsync"}, 32'(frameSync), 32'd0);
        chk({tag, "_grp"}, 32'(cntGrp), 32'(grp_exp));
    endtask

    // Starts from IDLE, streams n words and drops enable during bit stop_bit of the last one.
    task automatic run_words(input int n, input int stop_bit, input bit glitch, input int grp0);
        logic [11:0] w;
        int          k;
        int          r;
        req_cnt = 0;
        run_n   = n;
        enable  = 1'b1;
        tick();
        chk("req_get", 32'(bufGetWord), 32'd1);
        chk("req_ptr", 32'(bufRdPointer), 32'd0);
        chk("req_grp", 32'(cntGrp), 32'(grp0));
        chk("req_busy", 32'(busy), 32'd1);
        if (glitch) enable = 1'b0;
        tick();
        chk("wait_get", 32'(bufGetWord), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_strb", 32'(bitStrobe), 32'd0);
        for (int j = 0; j < 48 * n; j++) begin
            tick();
            if (glitch && j == 0) enable = 1'b1;
            k = j / 48;
            r = j % 48;
            w = run_data[k];
            chk("ser", 32'(serOut), 32'(w[11 - r / 4]));
            chk("strb", 32'(bitStrobe), 32'(r % 4 == 0));
            chk("fsync", 32'(frameSync), 32'(r == 0 && k % 4 == 0));
            chk("get", 32'(bufGetWord), 32'(r == 1));
            chk("ptr", 32'(bufRdPointer), 32'((k + 1) % 4));
            chk("grp", 32'(cntGrp), 32'((grp0 + (k + 1) / 4) % 3));
            chk("busy", 32'(busy), 32'd1);
            if (k == n - 1 && r == 4 * (11 - stop_bit) + 1) enable = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            check_idle("stop", (grp0 + n / 4) % 3);
        end
    endtask

    initial begin
        // Held in reset with noise on the inputs.
        for (int j = 0; j < 4; j++) begin
            enable = 1'($urandom);
            tick();
            chk("rst_outs", all_outs(), 32'd0);
        end
        enable = 1'b0;
        reset  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("rel_outs", all_outs(), 32'd0);
        end

        // Startup, gapless stream, frame/group wraps, stop during bit 5 of the last word.
        run_data = '{12'hA5C, 12'hFFF, 12'h000, 12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF,
                     12'h135, 12'h246, 12'h357, 12'h468, 12'h579, 12'h68A, 12'h79B, 12'h8AC};
        run_words(16, 5, 1'b0, 0);

        // Restart with an enable glitch in REQ/WAIT, stop during bit 5 of word 2.
        run_data[0] = 12'h3C3;
        run_data[1] = 12'h5A5;
        run_data[2] = 12'h0F0;
        run_words(3, 5, 1'b1, 1);

        // Asynchronous reset while bit 7 of a word is on the line.
        run_data[0] = 12'hFFF;
        run_n   = 1;
        req_cnt = 0;
        enable  = 1'b1;
        for (int j = 0; j < 2 + 19; j++) tick();
        chk("pre_rst_ser", 32'(serOut), 32'd1);
        chk("pre_rst_grp", 32'(cntGrp), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_outs", all_outs(), 32'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("hold_rst_outs", all_outs(), 32'd0);
        end
        reset = 1'b1;
        run_data[0] = 12'hC0F;
        run_data[1] = 12'h9E1;
        run_words(2, 5, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
